axis_iq_interleaver: RTL and testbench

Capture-side stage that takes simultaneous I/Q sample pairs from the ADC capture logic and emits them as a single interleaved AXI4-Stream: I beat tagged `tid=1`, then Q beat tagged `tid=0`. It sits directly upstream of the interleaved-to-continuous converter and drives that block's slave interface in the `aclk_s_i` domain. It decouples the non-backpressurable ADC side from the AXIS side with a pair FIFO and reports dropped pairs.

---
 rtl/axis_iq_interleaver.sv | 172 +++++++++++++++++
 tb/tb_axis_iq_interleaver.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_iq_interleaver.sv
// axis_iq_interleaver: buffers simultaneous I/Q pairs from the ADC capture logic in a pair FIFO.
// It emits them as one interleaved AXI4-Stream: the I beat with tid=1, then the Q beat with tid=0.
// Pairs that arrive while the FIFO is full are dropped whole and flagged.
// Optional feature macro: AXIS_IQ_OVF_CNT_EN adds a saturating dropped-pair counter on ovf_cnt_o.
module axis_iq_interleaver #(
    parameter int unsigned DW      = 16,
    parameter int unsigned AW_FIFO = 3
) (
    input  logic                 aclk_s_i,
    input  logic                 aresetn,
    input  logic                 ce,
    input  logic [DW-1:0]        adc_i_i,
    input  logic [DW-1:0]        adc_q_i,
    input  logic                 adc_valid_i,
    output logic [DW-1:0]        tdata_m_o,
    output logic [DW/8-1:0]      tstrb_m_o,
    output logic                 tid_m_o,
    output logic                 tvalid_m_o,
    input  logic                 tready_m_i,
    output logic                 overflow_o,
    output logic [15:0]          ovf_cnt_o,
    output logic [AW_FIFO:0]     fifo_level_o
);

    localparam int unsigned Depth = 1 << AW_FIFO;

    typedef enum logic [1:0] {StIdle, StSendI, StSendQ} state_e;

    state_e              state_q, state_d;
    logic [2*DW-1:0]     mem_q [Depth];
    logic [AW_FIFO-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW_FIFO:0]    level_q, level_d;
    logic                fifo_empty, fifo_full;
    logic                push_req, push, pop, drop, hs;
    logic [2*DW-1:0]     rd_pair;
    logic [DW-1:0]       tdata_q, tdata_d, q_hold_q, q_hold_d;
    logic                tid_q, tid_d, tvalid_q, tvalid_d;
    logic [DW/8-1:0]     tstrb_q, tstrb_d;
    logic                overflow_q;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == (AW_FIFO+1)'(Depth));
    assign push_req   = ce & adc_valid_i;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the pair.
    assign push       = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;
    assign rd_pair    = mem_q[rd_ptr_q];
    assign hs         = tvalid_q & tready_m_i;

    // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + (AW_FIFO+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (AW_FIFO+1)'(1);
        end
    end

    // FIFO pointers and level; reset flushes the FIFO.
    always_ff @(posedge aclk_s_i or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW_FIFO'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW_FIFO'(1);
            level_q <= level_d;
        end
    end

    // Pair storage, {Q, I}; contents need no reset since the pointers define validity.
    always_ff @(posedge aclk_s_i) begin
        if (push) mem_q[wr_ptr_q] <= {adc_q_i, adc_i_i};
    end

    // Output FSM next state: pops a pair into the output stage, then sends I followed by Q.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        tdata_d  = tdata_q;
        tid_d    = tid_q;
        tvalid_d = tvalid_q;
        q_hold_d = q_hold_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    tdata_d  = rd_pair[DW-1:0];
                    q_hold_d = rd_pair[2*DW-1:DW];
                    tid_d    = 1'b1;
                    tvalid_d = 1'b1;
                    state_d  = StSendI;
                end
            end
            StSendI: begin
                if (hs) begin
                    tdata_d = q_hold_q;
                    tid_d   = 1'b0;
                    state_d = StSendQ;
                end
            end
            StSendQ: begin
                if (hs) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        tdata_d  = rd_pair[DW-1:0];
                        q_hold_d = rd_pair[2*DW-1:DW];
                        tid_d    = 1'b1;
                        state_d  = StSendI;
                    end else begin
                        tvalid_d = 1'b0;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        tstrb_d = tvalid_d ? '1 : '0;
    end

    // Output FSM and registered AXIS outputs.
    always_ff @(posedge aclk_s_i or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            tdata_q    <= '0;
            q_hold_q   <= '0;
            tid_q      <= 1'b0;
            tvalid_q   <= 1'b0;
            tstrb_q    <= '0;
        end else begin
            state_q    <= state_d;
            tdata_q    <= tdata_d;
            q_hold_q   <= q_hold_d;
            tid_q      <= tid_d;
            tvalid_q   <= tvalid_d;
            tstrb_q    <= tstrb_d;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge aclk_s_i or negedge aresetn) begin
        if (!aresetn) overflow_q <= 1'b0;
        else          overflow_q <= overflow_q | drop;
    end

`ifdef AXIS_IQ_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    // Saturating dropped-pair counter.
    always_ff @(posedge aclk_s_i or negedge aresetn) begin
        if (!aresetn) begin
            ovf_cnt_q <= '0;
        end else if (drop && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = '0;
`endif

    assign tdata_m_o    = tdata_q;
    assign tstrb_m_o    = tstrb_q;
    assign tid_m_o      = tid_q;
    assign tvalid_m_o   = tvalid_q;
    assign overflow_o   = overflow_q;
    assign fifo_level_o = level_q;

endmodule

// File: tb/tb_axis_iq_interleaver.sv
// Self-checking bench for axis_iq_interleaver with a beat-queue reference model.
module tb_axis_iq_interleaver;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          aclk_s_i = 1'b0;
    logic          aresetn = 1'b0;
    logic          ce = 1'b0;
    logic          adc_valid_i = 1'b0;
    logic          tready_m_i = 1'b0;
    logic [DW-1:0] adc_i_i = '0;
    logic [DW-1:0] adc_q_i = '0;
    logic [DW-1:0] tdata_m_o;
    logic [1:0]    tstrb_m_o;
    logic          tid_m_o, tvalid_m_o, overflow_o;
    logic [15:0]   ovf_cnt_o;
    logic [AW:0]   fifo_level_o;

    int total = 0;
    int bad   = 0;

    axis_iq_interleaver #(.DW(DW), .AW_FIFO(AW)) dut (
        .aclk_s_i     (aclk_s_i),
        .aresetn      (aresetn),
        .ce           (ce),
        .adc_i_i      (adc_i_i),
        .adc_q_i      (adc_q_i),
        .adc_valid_i  (adc_valid_i),
        .tdata_m_o    (tdata_m_o),
        .tstrb_m_o    (tstrb_m_o),
        .tid_m_o      (tid_m_o),
        .tvalid_m_o   (tvalid_m_o),
        .tready_m_i   (tready_m_i),
        .overflow_o   (overflow_o),
        .ovf_cnt_o    (ovf_cnt_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 aclk_s_i = ~aclk_s_i;

    // Reference model: stored pairs, plus the beats the output stage still owes.
    typedef struct packed {logic [15:0] d; logic t;} beat_t;
    logic [31:0] fq[$];
    beat_t       ob[$];
    int          drops;
    bit          ovf;

    function automatic void model_reset();
        fq.delete();
        ob.delete();
        drops = 0;
        ovf   = 0;
    endfunction

    function automatic void model_step();
        bit hs, pop;
        logic [31:0] p;
        hs  = (ob.size() > 0) && tready_m_i;
        pop = (fq.size() > 0) && ((ob.size() == 0) || (hs && ob.size() == 1));
        if (hs) void'(ob.pop_front());
        if (pop) begin
            p = fq.pop_front();
            ob.push_back('{d: p[15:0], t: 1'b1});
            ob.push_back('{d: p[31:16], t: 1'b0});
        end
        if (ce && adc_valid_i) begin
            if (fq.size() < DEPTH) begin
                fq.push_back({adc_q_i, adc_i_i});
            end else begin
                drops++;
                ovf = 1;
            end
        end
    endfunction

    function automatic logic [15:0] exp_cnt();
`ifdef AXIS_IQ_OVF_CNT_EN
        return (drops > 65535) ? 16'hFFFF : 16'(drops);
`else
        return 16'd0;
`endif
    endfunction

    // {tvalid, tid, tdata, tstrb, level, overflow, ovf_cnt}; tid/tdata masked when not valid.
    function automatic logic [40:0] exp_vec();
        if (ob.size() > 0)
            return {1'b1, ob[0].t, ob[0].d, 2'b11, 4'(fq.size()), ovf, exp_cnt()};
        return {1'b0, 1'b0, 16'h0, 2'b00, 4'(fq.size()), ovf, exp_cnt()};
    endfunction

    function automatic logic [40:0] dut_vec();
        return {tvalid_m_o, tvalid_m_o ? tid_m_o : 1'b0, tvalid_m_o ? tdata_m_o : 16'h0,
                tstrb_m_o, fifo_level_o, overflow_o, ovf_cnt_o};
    endfunction

    task automatic cycle(input logic c, input logic v, input logic [15:0] i,
                         input logic [15:0] q, input logic r);
        @(negedge aclk_s_i);
        ce = c; adc_valid_i = v; adc_i_i = i; adc_q_i = q; tready_m_i = r;
        @(posedge aclk_s_i);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge aclk_s_i);
        aresetn = 1'b0;
        ce = 1'b0; adc_valid_i = 1'b0; tready_m_i = 1'b0;
        model_reset();
        @(negedge aclk_s_i);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge aclk_s_i);
        #1;
        total++;
        if ({tvalid_m_o, tid_m_o, tdata_m_o, tstrb_m_o, fifo_level_o, overflow_o, ovf_cnt_o}
            !== 41'h0) begin
            bad++;
            $display("FAIL reset_values got=%h want=0", dut_vec());
        end
        model_reset();
        @(negedge aclk_s_i);
        aresetn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        cycle(1, 1, 16'h1234, 16'hABCD, 1);
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL single_n got=%h want=%h", dut_vec(), exp_vec());
        end
        cycle(0, 0, 0, 0, 1);
        total++;
        if ({tvalid_m_o, tid_m_o, tdata_m_o, tstrb_m_o} !== {1'b1, 1'b1, 16'h1234, 2'b11}) begin
            bad++;
            $display("FAIL single_i_beat got=%b/%b/%h/%b want=1/1/1234/11",
                     tvalid_m_o, tid_m_o, tdata_m_o, tstrb_m_o);
        end
        cycle(0, 0, 0, 0, 1);
        total++;
        if ({tvalid_m_o, tid_m_o, tdata_m_o, tstrb_m_o} !== {1'b1, 1'b0, 16'hABCD, 2'b11}) begin
            bad++;
            $display("FAIL single_q_beat got=%b/%b/%h/%b want=1/0/abcd/11",
                     tvalid_m_o, tid_m_o, tdata_m_o, tstrb_m_o);
        end
        cycle(0, 0, 0, 0, 1);
        total++;
        if (tvalid_m_o !== 1'b0 || tstrb_m_o !== 2'b00) begin
            bad++; $display("FAIL single_idle got=%b/%b want=0/00", tvalid_m_o, tstrb_m_o);
        end
    endtask

    task automatic test_stall();
        do_reset();
        cycle(1, 1, 16'h5A5A, 16'hC3C3, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0, 0, 0);
            total++;
            if (dut_vec() !== exp_vec() || tdata_m_o !== 16'h5A5A || tid_m_o !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 1);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL stall_release%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cycle(1, 1, 16'($urandom), 16'($urandom), 0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL ovf_fill%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
        total++;
        if (fifo_level_o !== 4'd8 || overflow_o !== 1'b1) begin
            bad++; $display("FAIL ovf_flags got=%0d/%b want=8/1", fifo_level_o, overflow_o);
        end
        total++;
`ifdef AXIS_IQ_OVF_CNT_EN
        if (ovf_cnt_o !== 16'd1) begin
            bad++; $display("FAIL ovf_count got=%0d want=1", ovf_cnt_o);
        end
`else
        if (ovf_cnt_o !== 16'd0) begin
            bad++; $display("FAIL ovf_count got=%0d want=0", ovf_cnt_o);
        end
`endif
        for (int k = 0; k < 22; k++) begin
            cycle(0, 0, 0, 0, 1);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL ovf_drain%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_full_concurrent();
        do_reset();
        for (int k = 0; k < 9; k++) cycle(1, 1, 16'(k + 16'h100), 16'(k + 16'h200), 0);
        cycle(0, 0, 0, 0, 1);
        total++;
        if (dut_vec() !== exp_vec() || fifo_level_o !== 4'd8 || tid_m_o !== 1'b0) begin
            bad++; $display("FAIL full_sendq got=%h want=%h", dut_vec(), exp_vec());
        end
        cycle(1, 1, 16'h7777, 16'h8888, 1);
        total++;
        if (fifo_level_o !== 4'd8 || overflow_o !== 1'b0 || tid_m_o !== 1'b1) begin
            bad++;
            $display("FAIL full_pushpop got=%0d/%b/%b want=8/0/1",
                     fifo_level_o, overflow_o, tid_m_o);
        end
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 0, 0, 1);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL full_drain%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ce_off();
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1, 1, 16'($urandom), 16'($urandom), 0);
        for (int k = 0; k < 12; k++) begin
            cycle(0, 1'($urandom), 16'($urandom), 16'($urandom), 1);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL ce_off%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
        total++;
        if (fifo_level_o !== 4'd0 || overflow_o !== 1'b0 || tvalid_m_o !== 1'b0) begin
            bad++;
            $display("FAIL ce_off_end got=%0d/%b/%b want=0/0/0",
                     fifo_level_o, overflow_o, tvalid_m_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1, 1, 16'($urandom), 16'($urandom), 0);
        cycle(0, 0, 0, 0, 1);
        total++;
        if (tvalid_m_o !== 1'b1 || tid_m_o !== 1'b0 || fifo_level_o !== 4'd3) begin
            bad++;
            $display("FAIL mid_setup got=%b/%b/%0d want=1/0/3",
                     tvalid_m_o, tid_m_o, fifo_level_o);
        end
        tready_m_i = 1'b0;
        #2;
        aresetn = 1'b0;
        model_reset();
        #1;
        total++;
        if ({tvalid_m_o, tid_m_o, tdata_m_o, tstrb_m_o, fifo_level_o, overflow_o, ovf_cnt_o}
            !== 41'h0) begin
            bad++; $display("FAIL mid_async_reset got=%h want=0", dut_vec());
        end
        @(negedge aclk_s_i);
        aresetn = 1'b1;
        cycle(1, 1, 16'hBEEF, 16'hCAFE, 1);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 1);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL mid_after%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 7) != 0), 1'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 3) != 0));
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL random%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_full_concurrent();
        test_ce_off();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
